// File: rtl/cpu_step_controller.sv
// Debounced step/run buttons drive a one-cycle PC advance strobe, with jump-to-self halt detection.
// Optional PC breakpoint stop in RUN is compiled in with `define CPU_STEP_BREAKPOINT_EN.

module cpu_step_debounce #(
   parameter logic [15:0] DB_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic pulse_o
);
   logic        sync1_q;
   logic        sync2_q;
   logic        level_q;
   logic        level_prev_q;
   logic [15:0] cnt_q;

   // The level only flips after DB_CYCLES consecutive synchronized samples disagree with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= btn_i;
         sync2_q      <= sync1_q;
         level_prev_q <= level_q;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_CYCLES - 16'd1) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign pulse_o = level_q & ~level_prev_q;
endmodule

module cpu_step_controller #(
   parameter logic [15:0] DB_CYCLES = 16'd50000,
   parameter logic [23:0] RUN_DIV   = 24'd5000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_step,
   input  logic        btn_run,
   input  logic [4:0]  pc,
   input  logic [4:0]  next_pc,
   input  logic [4:0]  bp_addr,
   output logic        advance,
   output logic        running,
   output logic        halted,
   output logic        bp_hit,
   output logic [15:0] instr_count
);
   typedef enum logic [1:0] {S_IDLE, S_STEP, S_RUN, S_HALT} state_t;

   state_t      state_q;
   logic [23:0] presc_q;
   logic        advance_q;
   logic        running_q;
   logic        halted_q;
   logic [15:0] instr_count_q;
   logic        step_p;
   logic        run_p;
   logic        self_jump;
   logic        run_tick;

   cpu_step_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
      .clk(clk), .reset(reset), .btn_i(btn_step), .pulse_o(step_p)
   );
   cpu_step_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
      .clk(clk), .reset(reset), .btn_i(btn_run), .pulse_o(run_p)
   );

   assign self_jump = (next_pc == pc);
   assign run_tick  = (presc_q == RUN_DIV - 24'd1);

`ifdef CPU_STEP_BREAKPOINT_EN
   logic bp_hit_q;
   logic bp_match;
   assign bp_match = (next_pc == bp_addr);
   assign bp_hit   = bp_hit_q;
`else
   logic unused_bp;
   assign unused_bp = ^bp_addr;
   assign bp_hit    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         presc_q       <= '0;
         advance_q     <= 1'b0;
         running_q     <= 1'b0;
         halted_q      <= 1'b0;
         instr_count_q <= '0;
`ifdef CPU_STEP_BREAKPOINT_EN
         bp_hit_q      <= 1'b0;
`endif
      end else begin
         advance_q <= 1'b0;
`ifdef CPU_STEP_BREAKPOINT_EN
         if ((step_p || run_p) && state_q != S_HALT) begin
            bp_hit_q <= 1'b0;
         end
`endif
         case (state_q)
            S_IDLE: begin
               if (run_p) begin
                  state_q   <= S_RUN;
                  running_q <= 1'b1;
                  presc_q   <= '0;
               end else if (step_p) begin
                  state_q <= S_STEP;
               end
            end
            S_STEP: begin
               if (self_jump) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else begin
                  state_q       <= S_IDLE;
                  advance_q     <= 1'b1;
                  instr_count_q <= instr_count_q + 16'd1;
               end
            end
            S_RUN: begin
               // A pause press takes priority over a prescaler tick in the same cycle.
               if (run_p) begin
                  state_q   <= S_IDLE;
                  running_q <= 1'b0;
                  presc_q   <= '0;
               end else if (run_tick) begin
                  presc_q <= '0;
                  if (self_jump) begin
                     state_q   <= S_HALT;
                     running_q <= 1'b0;
                     halted_q  <= 1'b1;
                  end else begin
                     advance_q     <= 1'b1;
                     instr_count_q <= instr_count_q + 16'd1;
`ifdef CPU_STEP_BREAKPOINT_EN
                     if (bp_match) begin
                        state_q   <= S_IDLE;
                        running_q <= 1'b0;
                        bp_hit_q  <= 1'b1;
                     end
`endif
                  end
               end else begin
                  presc_q <= presc_q + 24'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign advance     = advance_q;
   assign running     = running_q;
   assign halted      = halted_q;
   assign instr_count = instr_count_q;
endmodule

// File: tb/tb_cpu_step_controller.sv
// Bench for cpu_step_controller: random button timing and PC streams checked against
// pulse times predicted from the button-to-advance latency rules.

module tb_cpu_step_controller;
   localparam int DB = 4;
   localparam int RD = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        btn_step = 1'b0;
   logic        btn_run = 1'b0;
   logic [4:0]  core_pc = 5'd0;
   logic [4:0]  next_pc;
   logic [4:0]  bp_addr = 5'd31;
   logic        advance;
   logic        running;
   logic        halted;
   logic        bp_hit;
   logic [15:0] instr_count;

   logic        halt_req = 1'b0;
   logic        pc_load = 1'b0;
   logic [4:0]  pc_load_val = 5'd0;
   int          cyc = 0;
   int          vectors = 0;
   int          errs = 0;
   int          adv_log[$];

   cpu_step_controller #(.DB_CYCLES(16'(DB)), .RUN_DIV(24'(RD))) dut (
      .clk(clk), .reset(reset), .btn_step(btn_step), .btn_run(btn_run),
      .pc(core_pc), .next_pc(next_pc), .bp_addr(bp_addr),
      .advance(advance), .running(running), .halted(halted),
      .bp_hit(bp_hit), .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Minimal core: PC follows next_pc on each advance; halt_req models a jump-to-self.
   always @(posedge clk) begin
      if (pc_load) core_pc <= pc_load_val;
      else if (advance) core_pc <= next_pc;
   end
   assign next_pc = halt_req ? core_pc : core_pc + 5'd1;

   always @(negedge clk) if (advance === 1'b1) adv_log.push_back(cyc);

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic do_reset;
      reset = 1'b1; tick(2); reset = 1'b0; tick(1);
   endtask

   task automatic load_pc(input logic [4:0] v);
      pc_load_val = v; pc_load = 1'b1; tick(1); pc_load = 1'b0;
   endtask

   task automatic press(input bit use_run, input int hold, output int t0);
      t0 = cyc;
      if (use_run) btn_run = 1'b1; else btn_step = 1'b1;
      tick(hold);
      btn_run = 1'b0; btn_step = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; tick(3);
      vectors += 5;
      if (advance !== 1'b0) begin errs++; $display("FAIL reset_advance got %b want 0", advance); end
      if (running !== 1'b0) begin errs++; $display("FAIL reset_running got %b want 0", running); end
      if (halted !== 1'b0) begin errs++; $display("FAIL reset_halted got %b want 0", halted); end
      if (bp_hit !== 1'b0) begin errs++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
      if (instr_count !== 16'h0) begin errs++; $display("FAIL reset_count got %h want 0000", instr_count); end
      reset = 1'b0; tick(10);
      vectors++;
      if (running !== 1'b0 || advance !== 1'b0) begin
         errs++; $display("FAIL idle_quiet got run=%b adv=%b want 0/0", running, advance);
      end
   endtask

   task automatic test_step;
      int exp_t[$];
      int n, t0, hold;
      logic [4:0] start;
      do_reset;
      start = 5'($urandom_range(0, 31));
      load_pc(start);
      adv_log.delete();
      n = $urandom_range(2, 4);
      for (int i = 0; i < n; i++) begin
         tick($urandom_range(0, 5));
         hold = (i == 0) ? 100 : $urandom_range(DB, 20);
         press(1'b0, hold, t0);
         exp_t.push_back(t0 + 4 + DB);
         tick(DB + 4);
         if (i == 0) begin
            vectors += 2;
            if (adv_log.size() != 1) begin errs++; $display("FAIL step_held_pulses got %0d want 1", adv_log.size()); end
            if (instr_count !== 16'd1) begin errs++; $display("FAIL step_first_count got %0d want 1", instr_count); end
         end
      end
      tick(10);
      vectors++;
      if (adv_log.size() != n) begin errs++; $display("FAIL step_pulses got %0d want %0d", adv_log.size(), n); end
      for (int i = 0; i < n && i < adv_log.size(); i++) begin
         vectors++;
         if (adv_log[i] != exp_t[i]) begin errs++; $display("FAIL step_time[%0d] got %0d want %0d", i, adv_log[i], exp_t[i]); end
      end
      vectors += 2;
      if (instr_count !== 16'(n)) begin errs++; $display("FAIL step_count got %0d want %0d", instr_count, n); end
      if (core_pc !== 5'(start + n)) begin errs++; $display("FAIL step_pc got %0d want %0d", core_pc, 5'(start + n)); end
   endtask

   task automatic test_glitch;
      int t;
      do_reset;
      adv_log.delete();
      for (int k = 0; k < 4; k++) begin
         press(k[0], $urandom_range(1, DB - 1), t);
         tick($urandom_range(DB + 2, 12));
      end
      tick(20);
      vectors += 3;
      if (adv_log.size() != 0) begin errs++; $display("FAIL glitch_pulses got %0d want 0", adv_log.size()); end
      if (instr_count !== 16'd0) begin errs++; $display("FAIL glitch_count got %0d want 0", instr_count); end
      if (running !== 1'b0) begin errs++; $display("FAIL glitch_running got %b want 0", running); end
   endtask

   task automatic test_run;
      int t0, t1, first, n, off, p;
      logic [4:0] start;
      do_reset;
      start = 5'($urandom_range(0, 31));
      load_pc(start);
      adv_log.delete();
      press(1'b1, $urandom_range(DB, DB + 6), t0);
      first = t0 + 3 + DB + RD;
      n = $urandom_range(3, 6);
      off = $urandom_range(1, RD - 2);
      p = first + (n - 1) * RD + off;
      wait_until(p - 2 - DB);
      vectors++;
      if (running !== 1'b1) begin errs++; $display("FAIL run_running got %b want 1", running); end
      press(1'b1, $urandom_range(DB, DB + 3), t1);
      wait_until(p + 1);
      vectors++;
      if (running !== 1'b0) begin errs++; $display("FAIL pause_running got %b want 0", running); end
      tick(3 * RD);
      vectors++;
      if (adv_log.size() != n) begin errs++; $display("FAIL run_pulses got %0d want %0d", adv_log.size(), n); end
      for (int i = 0; i < n && i < adv_log.size(); i++) begin
         vectors++;
         if (adv_log[i] != first + i * RD) begin
            errs++; $display("FAIL run_time[%0d] got %0d want %0d", i, adv_log[i], first + i * RD);
         end
      end
      vectors += 2;
      if (instr_count !== 16'(n)) begin errs++; $display("FAIL run_count got %0d want %0d", instr_count, n); end
      if (core_pc !== 5'(start + n)) begin errs++; $display("FAIL run_pc got %0d want %0d", core_pc, 5'(start + n)); end
   endtask

   task automatic test_halt;
      int t0, t, first;
      do_reset;
      load_pc(5'($urandom_range(0, 20)));
      adv_log.delete();
      press(1'b1, DB + 2, t0);
      first = t0 + 3 + DB + RD;
      wait_until(first + RD + 2);
      load_pc(5'd7);
      halt_req = 1'b1;
      wait_until(first + 2 * RD - 1);
      vectors++;
      if (halted !== 1'b0 || running !== 1'b1) begin
         errs++; $display("FAIL pre_halt got halted=%b run=%b want 0/1", halted, running);
      end
      tick(1);
      vectors++;
      if (halted !== 1'b1 || running !== 1'b0) begin
         errs++; $display("FAIL halt_state got halted=%b run=%b want 1/0", halted, running);
      end
      press(1'b0, DB + 2, t);
      tick(DB + 4);
      press(1'b1, DB + 2, t);
      tick(3 * RD);
      vectors += 4;
      if (adv_log.size() != 2) begin errs++; $display("FAIL halt_pulses got %0d want 2", adv_log.size()); end
      if (instr_count !== 16'd2) begin errs++; $display("FAIL halt_count got %0d want 2", instr_count); end
      if (halted !== 1'b1) begin errs++; $display("FAIL halt_sticky got %b want 1", halted); end
      if (core_pc !== 5'd7) begin errs++; $display("FAIL halt_pc got %0d want 7", core_pc); end
      reset = 1'b1; tick(1);
      vectors += 3;
      if (halted !== 1'b0) begin errs++; $display("FAIL halt_reset got %b want 0", halted); end
      if (instr_count !== 16'd0) begin errs++; $display("FAIL halt_reset_count got %0d want 0", instr_count); end
      if (running !== 1'b0) begin errs++; $display("FAIL halt_reset_run got %b want 0", running); end
      reset = 1'b0; halt_req = 1'b0;
   endtask

   task automatic test_reset_pending;
      int t0, first;
      do_reset;
      load_pc(5'd2);
      press(1'b1, DB + 2, t0);
      first = t0 + 3 + DB + RD;
      wait_until(first - 1);
      reset = 1'b1;
      tick(1);
      vectors += 3;
      if (advance !== 1'b0) begin errs++; $display("FAIL pending_drop got %b want 0", advance); end
      if (instr_count !== 16'd0) begin errs++; $display("FAIL pending_count got %0d want 0", instr_count); end
      if (running !== 1'b0) begin errs++; $display("FAIL pending_run got %b want 0", running); end
      reset = 1'b0;
   endtask

   task automatic test_wrap;
      int t0;
      do_reset;
      load_pc(5'($urandom_range(0, 30)));
      force dut.instr_count_q = 16'hFFFF;
      tick(1);
      release dut.instr_count_q;
      tick(1);
      vectors++;
      if (instr_count !== 16'hFFFF) begin errs++; $display("FAIL wrap_preload got %h want ffff", instr_count); end
      adv_log.delete();
      press(1'b0, DB + 2, t0);
      wait_until(t0 + 4 + DB);
      vectors += 2;
      if (advance !== 1'b1) begin errs++; $display("FAIL wrap_advance got %b want 1", advance); end
      if (instr_count !== 16'h0000) begin errs++; $display("FAIL wrap_count got %h want 0000", instr_count); end
      tick(10);
      vectors++;
      if (adv_log.size() != 1) begin errs++; $display("FAIL wrap_pulses got %0d want 1", adv_log.size()); end
   endtask

   task automatic test_breakpoint;
      int t0, t1, first;
      do_reset;
      bp_addr = 5'd3;
      load_pc(5'd0);
      adv_log.delete();
      press(1'b1, DB + 2, t0);
      first = t0 + 3 + DB + RD;
      wait_until(first + 6 * RD);
`ifdef CPU_STEP_BREAKPOINT_EN
      vectors += 5;
      if (adv_log.size() != 3) begin errs++; $display("FAIL bp_pulses got %0d want 3", adv_log.size()); end
      if (instr_count !== 16'd3) begin errs++; $display("FAIL bp_count got %0d want 3", instr_count); end
      if (bp_hit !== 1'b1) begin errs++; $display("FAIL bp_hit got %b want 1", bp_hit); end
      if (running !== 1'b0) begin errs++; $display("FAIL bp_running got %b want 0", running); end
      if (core_pc !== 5'd3) begin errs++; $display("FAIL bp_pc got %0d want 3", core_pc); end
      press(1'b1, DB + 2, t1);
      wait_until(t1 + 3 + DB);
      vectors += 2;
      if (bp_hit !== 1'b0) begin errs++; $display("FAIL bp_clear got %b want 1'b0", bp_hit); end
      if (running !== 1'b1) begin errs++; $display("FAIL bp_resume got %b want 1", running); end
      wait_until(t1 + 4 + DB + RD);
      vectors += 2;
      if (core_pc !== 5'd4) begin errs++; $display("FAIL bp_resume_pc got %0d want 4", core_pc); end
      if (instr_count !== 16'd4) begin errs++; $display("FAIL bp_resume_count got %0d want 4", instr_count); end
`else
      vectors += 3;
      if (adv_log.size() != 6) begin errs++; $display("FAIL nobp_pulses got %0d want 6", adv_log.size()); end
      if (bp_hit !== 1'b0) begin errs++; $display("FAIL nobp_hit got %b want 0", bp_hit); end
      if (running !== 1'b1) begin errs++; $display("FAIL nobp_running got %b want 1", running); end
`endif
      press(1'b1, DB + 2, t1);
      tick(DB + 4);
      bp_addr = 5'd31;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_step;
      test_glitch;
      test_run;
      test_halt;
      test_reset_pending;
      test_wrap;
      test_breakpoint;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
